// File: rtl/exec_pkg.sv
// exec_unit shared definitions: opcodes, FSM states
// and the decode helper that maps RV32I fields to EXU ops.
package exec_pkg;

    localparam int EXU_OPW = 4;

    localparam logic [EXU_OPW-1:0] EXU_ADD  = 4'd0;
    localparam logic [EXU_OPW-1:0] EXU_SUB  = 4'd1;
    localparam logic [EXU_OPW-1:0] EXU_SLL  = 4'd2;
    localparam logic [EXU_OPW-1:0] EXU_SLT  = 4'd3;
    localparam logic [EXU_OPW-1:0] EXU_SLTU = 4'd4;
    localparam logic [EXU_OPW-1:0] EXU_XOR  = 4'd5;
    localparam logic [EXU_OPW-1:0] EXU_SRL  = 4'd6;
    localparam logic [EXU_OPW-1:0] EXU_SRA  = 4'd7;
    localparam logic [EXU_OPW-1:0] EXU_OR   = 4'd8;
    localparam logic [EXU_OPW-1:0] EXU_AND  = 4'd9;
    localparam logic [EXU_OPW-1:0] EXU_MUL  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_HOLD  = 2'd3
    } exu_state_e;

    // SUB only exists in the register form; funct7[5]
    // on an immediate ADD is part of the immediate.
    function automatic logic [EXU_OPW-1:0] exu_decode(
        input logic [2:0] funct3,
        input logic       funct7_b5,
        input logic       itype
    );
        logic [EXU_OPW-1:0] op;
        op = EXU_ADD;
        case (funct3)
            3'b000: op = (!itype && funct7_b5)
                         ? EXU_SUB : EXU_ADD;
            3'b001: op = EXU_SLL;
            3'b010: op = EXU_SLT;
            3'b011: op = EXU_SLTU;
            3'b100: op = EXU_XOR;
            3'b101: op = funct7_b5 ? EXU_SRA : EXU_SRL;
            3'b110: op = EXU_OR;
            3'b111: op = EXU_AND;
            default: op = EXU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/exec_seq_mul.sv
// Iterative shift-add multiplier, low XLEN bits of a*b.
// The first partial product is taken on the start edge.
module exec_seq_mul
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] p_o
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] acc_d;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [CW-1:0]   cnt_q;
    logic            run_q;

    // Next accumulator value for the current partial product.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    // Done is flagged during the last step so the product
    // can be captured on the same edge that computes it.
    assign done_o = run_q && (cnt_q == CW'(1));
    assign p_o    = acc_d;

    // Load operands on start, then one add/shift per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            acc_q    <= b_i[0] ? a_i : '0;
            mcand_q  <= a_i << 1;
            mplier_q <= b_i >> 1;
            cnt_q    <= CW'(XLEN - 1);
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// RV32I execute unit with valid/ready handshakes,
// optional iterative shifter and shift-add multiplier.
module exec_unit
    import exec_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_ITER = 0,
    parameter int MUL_EN     = 1,
    parameter int SHW        = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] y_o,
    output logic            err_o,
    output logic            busy_o
);

    exu_state_e      state_q;
    logic [XLEN-1:0] y_q;
    logic            err_q;
    logic            valid_q;
    logic            busy_q;
    logic [XLEN-1:0] sh_q;
    logic [XLEN-1:0] sh_d;
    logic [3:0]      op_q;
    logic [SHW-1:0]  cnt_q;

    logic            accept;
    logic            is_shift;
    logic            is_alu;
    logic            is_mul;
    logic            go_shift;
    logic            go_alu;
    logic            go_mul;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] sh_first;
    logic            mul_done;
    logic [XLEN-1:0] mul_p;

    function automatic logic [XLEN-1:0] step1(
        input logic [XLEN-1:0] v,
        input logic [3:0]      op
    );
        if (op == EXU_SLL) begin
            return v << 1;
        end
        if (op == EXU_SRL) begin
            return v >> 1;
        end
        return {v[XLEN-1], v[XLEN-1:1]};
    endfunction

    assign shamt = b_i[SHW-1:0];

    assign in_ready_o = !reset &&
                        ((state_q == ST_IDLE) ||
                         (state_q == ST_HOLD && out_ready_i));
    assign accept = in_valid_i && in_ready_o;

    // Classify the incoming op; the go_* flags are exclusive.
    always_comb begin
        is_shift = (op_i == EXU_SLL) || (op_i == EXU_SRL) ||
                   (op_i == EXU_SRA);
        is_alu   = (op_i <= EXU_AND);
        is_mul   = (op_i == EXU_MUL);
        go_shift = (SHIFT_ITER != 0) && is_shift;
        go_alu   = is_alu && !go_shift;
        go_mul   = (MUL_EN != 0) && is_mul;
    end

    // Single-cycle arithmetic on the live operands.
    always_comb begin
        alu_y = '0;
        case (op_i)
            EXU_ADD:  alu_y = a_i + b_i;
            EXU_SUB:  alu_y = a_i - b_i;
            EXU_SLL:  alu_y = a_i << shamt;
            EXU_SLT:  alu_y = {{(XLEN-1){1'b0}},
                               ($signed(a_i) < $signed(b_i))};
            EXU_SLTU: alu_y = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            EXU_XOR:  alu_y = a_i ^ b_i;
            EXU_SRL:  alu_y = a_i >> shamt;
            EXU_SRA:  alu_y = $signed(a_i) >>> shamt;
            EXU_OR:   alu_y = a_i | b_i;
            EXU_AND:  alu_y = a_i & b_i;
            default:  alu_y = '0;
        endcase
    end

    // One-bit shift steps: the first is taken on accept so
    // that a shift by N is ready N cycles after issue.
    always_comb begin
        sh_first = step1(a_i, op_i);
        sh_d     = step1(sh_q, op_q);
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            exec_seq_mul #(
                .XLEN(XLEN)
            ) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start_i (accept && go_mul),
                .a_i     (a_i),
                .b_i     (b_i),
                .done_o  (mul_done),
                .p_o     (mul_p)
            );
        end else begin : g_no_mul
            assign mul_done = 1'b0;
            assign mul_p    = '0;
        end
    endgenerate

    // Control FSM with registered result and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            sh_q    <= '0;
            op_q    <= EXU_ADD;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        op_q  <= op_i;
                        err_q <= 1'b0;
                        unique case (1'b1)
                            go_shift: begin
                                if (shamt == '0) begin
                                    y_q     <= a_i;
                                    valid_q <= 1'b1;
                                    state_q <= ST_HOLD;
                                end else if (shamt == SHW'(1)) begin
                                    y_q     <= sh_first;
                                    valid_q <= 1'b1;
                                    state_q <= ST_HOLD;
                                end else begin
                                    sh_q    <= sh_first;
                                    cnt_q   <= shamt;
                                    valid_q <= 1'b0;
                                    busy_q  <= 1'b1;
                                    state_q <= ST_SHIFT;
                                end
                            end
                            go_alu: begin
                                y_q     <= alu_y;
                                valid_q <= 1'b1;
                                state_q <= ST_HOLD;
                            end
                            go_mul: begin
                                valid_q <= 1'b0;
                                busy_q  <= 1'b1;
                                state_q <= ST_MUL;
                            end
                            default: begin
                                y_q     <= '0;
                                err_q   <= 1'b1;
                                valid_q <= 1'b1;
                                state_q <= ST_HOLD;
                            end
                        endcase
                    end else if (state_q == ST_HOLD && out_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == SHW'(2)) begin
                        y_q     <= sh_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        y_q     <= mul_p;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid_o = valid_q;
    assign y_o         = y_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: one barrel-shift/MUL
// instance (d0) and one iterative-shift/no-MUL instance (d1).
module tb_exec_unit;
    import exec_pkg::*;

    typedef struct {
        int          d;
        logic [31:0] y;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [3:0]  op        [2];
    logic [31:0] a         [2];
    logic [31:0] b         [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] y         [2];
    logic        err       [2];
    logic        busy      [2];

    exp_t sbq[$];
    exp_t e;
    bit   pres  [2];
    int   first [2];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    exec_unit #(.XLEN(32), .SHIFT_ITER(0), .MUL_EN(1)) u_d0 (
        .clk(clk), .reset(rst),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .op_i(op[0]), .a_i(a[0]), .b_i(b[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .y_o(y[0]), .err_o(err[0]), .busy_o(busy[0])
    );

    exec_unit #(.XLEN(32), .SHIFT_ITER(1), .MUL_EN(0)) u_d1 (
        .clk(clk), .reset(rst),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .op_i(op[1]), .a_i(a[1]), .b_i(b[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .y_o(y[1]), .err_o(err[1]), .busy_o(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h",
                     nm, act, exp);
        end
    endtask

    // Drive an op now (caller is at a negedge) and push the
    // expected result once the unit is seen ready.
    task automatic iss_now(input int d, input logic [3:0] o,
                           input logic [31:0] av,
                           input logic [31:0] bv,
                           input logic [31:0] ey,
                           input logic ee, input int lat);
        exp_t x;
        int k;
        op[d] = o;
        a[d] = av;
        b[d] = bv;
        in_valid[d] = 1'b1;
        #1;
        k = 0;
        while (!in_ready[d] && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!in_ready[d]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout d%0d op %0d: in_ready 0, expected 1",
                     d, o);
            in_valid[d] = 1'b0;
            return;
        end
        x.d = d;
        x.y = ey;
        x.err = ee;
        x.cyc = cyc + lat;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        op[d] = 4'($urandom);
        a[d] = $urandom;
        b[d] = $urandom;
    endtask

    task automatic iss(input int d, input logic [3:0] o,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ey, input logic ee,
                       input int lat);
        @(negedge clk);
        iss_now(d, o, av, bv, ey, ee, lat);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, expected 0",
                     sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: note first-valid cycle, compare on handshake.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            pres[0] = 1'b0;
            pres[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid[d]) begin
                    if (!pres[d]) begin
                        pres[d] = 1'b1;
                        first[d] = cyc;
                    end
                    if (out_ready[d]) begin
                        pres[d] = 1'b0;
                        n_cmp++;
                        if (sbq.size() == 0) begin
                            n_bad++;
                            $display("FAIL unexpected d%0d: y=0x%08h err=%0b, expected no result",
                                     d, y[d], err[d]);
                        end else begin
                            e = sbq.pop_front();
                            if (e.d != d || y[d] !== e.y ||
                                err[d] !== e.err) begin
                                n_bad++;
                                $display("FAIL result d%0d: y=0x%08h err=%0b, expected d%0d y=0x%08h err=%0b",
                                         d, y[d], err[d], e.d, e.y, e.err);
                            end
                            n_cmp++;
                            if (first[d] != e.cyc) begin
                                n_bad++;
                                $display("FAIL latency d%0d: valid at cycle %0d, expected %0d",
                                         d, first[d], e.cyc);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b1;
            op[d] = '0;
            a[d] = '0;
            b[d] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_valid d%0d", d), 32'(out_valid[d]), 0);
            chk($sformatf("rst_busy d%0d", d), 32'(busy[d]), 0);
            chk($sformatf("rst_err d%0d", d), 32'(err[d]), 0);
            chk($sformatf("rst_y d%0d", d), y[d], 0);
            chk($sformatf("rst_ready d%0d", d), 32'(in_ready[d]), 0);
        end
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(in_ready[0]), 1);

        // d0: single-cycle ALU ops
        iss(0, EXU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1);
        iss(0, EXU_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 1);
        iss(0, EXU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 1);
        iss(0, EXU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1);
        iss(0, EXU_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1);
        iss(0, EXU_SLL, 32'h1, 32'h21, 32'h2, 0, 1);
        iss(0, EXU_SRL, 32'h8000_0000, 32'h1F, 32'h1, 0, 1);
        iss(0, EXU_OR, 32'hF0, 32'h0F, 32'hFF, 0, 1);
        iss(0, EXU_AND, 32'hF0, 32'h3C, 32'h30, 0, 1);
        iss(0, 4'hF, 32'h1234, 32'h5678, 32'h0, 1, 1);
        iss(0, EXU_ADD, 32'h5, 32'h6, 32'hB, 0, 1);
        drain();

        // d0: multiplier
        iss(0, EXU_MUL, 32'd12345, 32'd6789, 32'd83810205, 0, 32);
        iss(0, EXU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0, 32);
        drain();

        // d0: backpressure, then back-to-back issue
        out_ready[0] = 1'b0;
        iss(0, EXU_ADD, 32'd3, 32'd4, 32'd7, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_valid %0d", i), 32'(out_valid[0]), 1);
            chk($sformatf("bp_y %0d", i), y[0], 32'd7);
            chk($sformatf("bp_ready %0d", i), 32'(in_ready[0]), 0);
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        iss_now(0, EXU_XOR, 32'hF0, 32'hFF, 32'h0F, 0, 1);
        drain();

        // d1: iterative shifter, MUL illegal
        iss(1, EXU_SLL, 32'h1, 32'h5, 32'h20, 0, 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("sh_busy %0d", i), 32'(busy[1]), 1);
            chk($sformatf("sh_ready %0d", i), 32'(in_ready[1]), 0);
        end
        drain();
        iss(1, EXU_SLL, 32'h1, 32'h0, 32'h1, 0, 1);
        iss(1, EXU_SLL, 32'h3, 32'h1, 32'h6, 0, 1);
        iss(1, EXU_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 4);
        iss(1, EXU_SRL, 32'h80, 32'h3, 32'h10, 0, 3);
        iss(1, EXU_MUL, 32'h3, 32'h4, 32'h0, 1, 1);
        iss(1, EXU_ADD, 32'h2, 32'h3, 32'h5, 0, 1);
        drain();

        // d0: reset during a multiply aborts it silently
        iss(0, EXU_MUL, 32'd5, 32'd7, 32'd35, 0, 32);
        repeat (9) @(negedge clk);
        @(negedge clk);
        #1;
        chk("mul_busy_c10", 32'(busy[0]), 1);
        rst = 1'b1;
        #1;
        chk("rst_ready_d0", 32'(in_ready[0]), 0);
        chk("rst_ready_d1", 32'(in_ready[1]), 0);
        @(negedge clk);
        #1;
        chk("abort_valid", 32'(out_valid[0]), 0);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_y", y[0], 0);
        sbq.delete();
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(in_ready[0]), 1);
        repeat (40) @(negedge clk);
        iss(0, EXU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
